// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin process scheduler with per-slot saved PCs,
// instruction-quantum preemption, blocking I/O and process create/terminate.
module quantum_scheduler #(
  parameter int NUM_PROC = 10,
  parameter int QUANTUM = 16,
  parameter int PC_WIDTH = 32,
  localparam int PID_W = $clog2(NUM_PROC),
  localparam int QW = $clog2(QUANTUM + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                instr_retire,
  input  logic [PC_WIDTH-1:0] cur_pc,
  input  logic                create_valid,
  input  logic [PC_WIDTH-1:0] create_pc,
  output logic                create_ready,
  output logic [PID_W-1:0]    create_pid,
  input  logic                end_proc,
  input  logic                io_block,
  input  logic                io_done,
  input  logic [PID_W-1:0]    io_pid,
  output logic                switch,
  output logic [PC_WIDTH-1:0] new_pc,
  output logic [PID_W-1:0]    cur_pid,
  output logic                running,
  output logic [QW-1:0]       quantum_left
);
  typedef enum logic [1:0] {IDLE, PICK, RUN} state_t;
  typedef enum logic [1:0] {FREE, READY, BLOCKED} slot_t;
  state_t state;
  slot_t slot_st [NUM_PROC];
  logic [PC_WIDTH-1:0] slot_pc [NUM_PROC];
  logic any_ready, found;
  logic [PID_W-1:0] pick_pid;
  logic slice_end;
  function automatic int wrap(input int v);
    return v >= NUM_PROC ? v - NUM_PROC : v;
  endfunction
  // Scan offsets from far to near so the nearest READY slot after cur_pid wins.
  always_comb begin
    found = 1'b0;
    pick_pid = '0;
    any_ready = 1'b0;
    create_ready = 1'b0;
    create_pid = '0;
    for (int k = NUM_PROC; k >= 1; k--) begin
      if (slot_st[wrap(int'(cur_pid) + k)] == READY) begin
        found = 1'b1;
        pick_pid = PID_W'(wrap(int'(cur_pid) + k));
      end
    end
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      any_ready = any_ready | (slot_st[i] == READY);
      if (slot_st[i] == FREE) begin
        create_ready = 1'b1;
        create_pid = PID_W'(i);
      end
    end
  end
  assign slice_end = end_proc | io_block | (instr_retire & (quantum_left == QW'(1)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      switch <= 1'b0;
      running <= 1'b0;
      cur_pid <= '0;
      new_pc <= '0;
      quantum_left <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        slot_st[i] <= FREE;
        slot_pc[i] <= '0;
      end
    end else begin
      switch <= 1'b0;
      if (create_valid && create_ready) begin
        slot_st[create_pid] <= READY;
        slot_pc[create_pid] <= create_pc;
      end
      if (io_done && int'(io_pid) < NUM_PROC && slot_st[io_pid] == BLOCKED)
        slot_st[io_pid] <= READY;
      case (state)
        IDLE: if (enable && any_ready) state <= PICK;
        PICK: begin
          state <= found ? RUN : IDLE;
          running <= found;
          switch <= found;
          if (found) begin
            cur_pid <= pick_pid;
            new_pc <= slot_pc[pick_pid];
            quantum_left <= QW'(QUANTUM);
          end
        end
        RUN: if (!switch) begin
          if (instr_retire) quantum_left <= quantum_left - 1'b1;
          if (slice_end) begin
            slot_pc[cur_pid] <= cur_pc;
            slot_st[cur_pid] <= end_proc ? FREE : io_block ? BLOCKED : READY;
            state <= PICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin process scheduler with per-process PC save slots and instruction-quantum preemption, generalising the single-process quantum counter to NUM_PROC process slots with blocking I/O and process creation/termination. Sits beside the CPU's PC register: the CPU reports retired instructions, process events and its current PC; the scheduler returns a one-cycle `switch` pulse with the PC to load and the PID now running. It replaces the fixed context-switch, I/O and end-of-process PC vectors with hardware dispatch.

## Interface
- NUM_PROC, 10, number of process slots (2..16)
- QUANTUM, 16, instructions retired per time slice (>=1)
- PC_WIDTH, 32, PC width
- PID_W (derived), clog2(NUM_PROC); QW (derived), clog2(QUANTUM+1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- enable  in  1  scheduling allowed (BIOS finished); gates only IDLE->PICK
- instr_retire  in  1  current process retired one instruction this cycle
- cur_pc  in  PC_WIDTH  PC of the current process's next instruction
- create_valid  in  1  request to create a process
- create_pc  in  PC_WIDTH  entry PC of the new process
- create_ready  out  1  at least one FREE slot (combinational)
- create_pid  out  PID_W  lowest-index FREE slot (combinational)
- end_proc  in  1  current process terminates
- io_block  in  1  current process issued IN; it blocks
- io_done  in  1  input delivered to process io_pid
- io_pid  in  PID_W  target of io_done
- switch  out  1  one-cycle pulse: CPU loads new_pc
- new_pc  out  PC_WIDTH  PC to load (registered)
- cur_pid  out  PID_W  dispatched PID (registered)
- running  out  1  a process is dispatched
- quantum_left  out  QW  remaining instructions in slice

## Operation
- Slot table: per slot 2-bit state FREE/READY/BLOCKED plus saved PC. Running process is READY and indexed by cur_pid.
- FSM: IDLE, PICK, RUN.
- IDLE: running=0. If enable and any READY slot -> PICK.
- PICK: rotating search from (cur_pid+1) mod NUM_PROC, wrapping, over READY slots, done combinationally in one cycle. Hit: register cur_pid, new_pc=saved PC, quantum_left=QUANTUM, switch=1 next cycle, -> RUN. No hit: -> IDLE, running=0.
- RUN: each instr_retire decrements quantum_left. A switch event is end_proc, io_block, or instr_retire with quantum_left==1. At that edge, cur_pc is saved to slot cur_pid; state becomes FREE (end_proc), BLOCKED (io_block) or stays READY (expiry); -> PICK.
- Priority when simultaneous: end_proc > io_block > expiry.
- Creation: create_valid && create_ready writes slot create_pid = READY, PC = create_pc, in any state. Uses the pre-edge table, so a slot freed on the same edge is unavailable.
- io_done: sets slot io_pid BLOCKED->READY in any state. Ignored unless the slot is BLOCKED.
- Sole READY process expiring: re-dispatched to itself, with switch still pulsed and new_pc equal to the saved cur_pc.
- Deasserting enable while in RUN has no effect on the current slice.

## Timing
- Reset values: all slots FREE, saved PCs 0, state IDLE, switch=0, running=0, cur_pid=0, new_pc=0, quantum_left=0. Asynchronous assertion mid-slice discards all slots immediately.
- Event sampled at edge E -> PICK during cycle E..E+1 -> switch=1, new_pc and cur_pid valid in cycle E+1..E+2. Latency: 2 edges.
- running=1 from the switch cycle until return to IDLE.
- instr_retire, end_proc and io_block are ignored outside RUN and during the switch cycle. The CPU stalls during PICK and switch.
- IDLE->PICK->switch: 2 edges after the first cycle in which enable and READY are both true.
- create_ready and create_pid are combinational from the slot table. create_pid is valid only while create_ready=1.

## Test plan
- NUM_PROC=4, QUANTUM=3, enable=1; create pc 100 then 200 -> create_pid 0 then 1. PID0 dispatched with new_pc=100 and one switch pulse. After 3 retires at cur_pc=103: switch, cur_pid=1, new_pc=200. After 3 more retires: switch, cur_pid=0, new_pc=103.
- Single process, QUANTUM=2: two retires -> switch re-dispatches PID0 with new_pc equal to its cur_pc; quantum_left reloads to 2.
- PID1 running, io_block with cur_pc=250 -> PID0 dispatched. io_done io_pid=1 -> PID1 READY; at the next expiry PID1 resumes with new_pc=250. io_done to a FREE slot -> no change.
- end_proc and io_block asserted on the same edge -> slot FREE, create_ready=1, create_pid equals that slot. With the last process ended -> IDLE, running=0, no switch.
- Fill all 4 slots -> create_ready=0, and create_valid is ignored. Assert reset mid-slice -> all outputs return to reset values without waiting for a clock edge.
